// File: rtl/rcc_rst_seq_if.sv
// Reset sequencer bus: lock/request inputs and the released domain resets.
// The controller side drives requests; the sequencer side drives resets.
interface rcc_rst_seq_if;
    logic       pll_locked;
    logic       sysresetreq;
    logic       wdt_rst_req;
    logic       cause_clr;
    logic       apb0_rstn;
    logic       apb1_rstn;
    logic       sys_rstn;
    logic       rst_done;
    logic [2:0] rst_cause;

    modport master (
        output pll_locked,
        output sysresetreq,
        output wdt_rst_req,
        output cause_clr,
        input  apb0_rstn,
        input  apb1_rstn,
        input  sys_rstn,
        input  rst_done,
        input  rst_cause
    );

    modport slave (
        input  pll_locked,
        input  sysresetreq,
        input  wdt_rst_req,
        input  cause_clr,
        output apb0_rstn,
        output apb1_rstn,
        output sys_rstn,
        output rst_done,
        output rst_cause
    );
endinterface

// File: rtl/rcc_rst_seq.sv
// RCC reset sequencer: qualifies PLL lock, releases APB0/APB1/SYS in order,
// re-asserts on lock loss or soft requests, and keeps sticky reset causes.
module rcc_rst_seq #(
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned STAGE_GAP          = 16,
    parameter int unsigned SOFT_RST_CYCLES    = 32,
    parameter int unsigned CNT_W              = 16
) (
    input  logic        sys_root_clk,
    input  logic        sys_root_rst,
    rcc_rst_seq_if.slave bus
);
    typedef enum logic [2:0] {
        WAIT_LOCK,
        STABLE,
        REL0,
        REL1,
        RUN,
        SOFT
    } state_t;

    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] G_LAST = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] S_LAST = CNT_W'(SOFT_RST_CYCLES - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             sync1;
    logic             lock_s;
    logic [2:0]       cause;
    logic [2:0]       cause_nx;
    logic             lock_loss;
    logic             soft_go;
    logic             apb0_q;
    logic             apb1_q;
    logic             sys_q;
    logic             done_q;

    // Lock loss overrides everything, including a soft request this cycle.
    assign lock_loss = !lock_s && (state != WAIT_LOCK);
    assign soft_go   = (state == RUN) && !lock_loss
                     && (bus.sysresetreq || bus.wdt_rst_req);

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        cause_nx = bus.cause_clr ? 3'b000 : cause;
        unique case (state)
            WAIT_LOCK: if (lock_s) state_nx = STABLE;
            STABLE: begin
                if (cnt == L_LAST) state_nx = REL0;
                else               cnt_nx   = cnt + 1'b1;
            end
            REL0: begin
                if (cnt == G_LAST) state_nx = REL1;
                else               cnt_nx   = cnt + 1'b1;
            end
            REL1: begin
                if (cnt == G_LAST) state_nx = RUN;
                else               cnt_nx   = cnt + 1'b1;
            end
            RUN: if (soft_go) state_nx = SOFT;
            SOFT: begin
                if (cnt == S_LAST) state_nx = REL0;
                else               cnt_nx   = cnt + 1'b1;
            end
            default: state_nx = WAIT_LOCK;
        endcase
        if (soft_go) begin
            cause_nx[1] = cause_nx[1] | bus.sysresetreq;
            cause_nx[2] = cause_nx[2] | bus.wdt_rst_req;
        end
        if (lock_loss) begin
            state_nx = WAIT_LOCK;
            cnt_nx   = '0;
            // Loss during qualification restarts without being recorded.
            if (state != STABLE) cause_nx[0] = 1'b1;
        end
    end

    always_ff @(posedge sys_root_clk) begin
        if (sys_root_rst) begin
            state  <= WAIT_LOCK;
            cnt    <= '0;
            sync1  <= 1'b0;
            lock_s <= 1'b0;
            cause  <= 3'b000;
            apb0_q <= 1'b0;
            apb1_q <= 1'b0;
            sys_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            sync1  <= bus.pll_locked;
            lock_s <= sync1;
            cause  <= cause_nx;
            apb0_q <= (state_nx == REL0) || (state_nx == REL1)
                   || (state_nx == RUN);
            apb1_q <= (state_nx == REL1) || (state_nx == RUN);
            sys_q  <= (state_nx == RUN);
            done_q <= (state_nx == RUN);
        end
    end

    assign bus.apb0_rstn = apb0_q;
    assign bus.apb1_rstn = apb1_q;
    assign bus.sys_rstn  = sys_q;
    assign bus.rst_done  = done_q;
    assign bus.rst_cause = cause;
endmodule

// File: tb/tb_rcc_rst_seq.sv
// Directed bench for rcc_rst_seq with L=8, G=4, S=6.
// Outputs are packed as {rst_done, sys_rstn, apb1_rstn, apb0_rstn}.
module tb_rcc_rst_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    rcc_rst_seq_if bus();

    rcc_rst_seq #(
        .LOCK_STABLE_CYCLES(8),
        .STAGE_GAP(4),
        .SOFT_RST_CYCLES(6),
        .CNT_W(16)
    ) dut (
        .sys_root_clk(clk),
        .sys_root_rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs();
        return {bus.rst_done, bus.sys_rstn, bus.apb1_rstn, bus.apb0_rstn};
    endfunction

    // Expected output vector r edges after a window that releases at a0.
    function automatic logic [3:0] seq_exp(int r, int a0);
        logic [3:0] v;
        v[0] = (r >= a0);
        v[1] = (r >= a0 + 4);
        v[2] = (r >= a0 + 8);
        v[3] = (r >= a0 + 8);
        return v;
    endfunction

    task automatic boot(input string tag);
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk(tag, 32'(outs()), 32'(seq_exp(e, 11)));
        end
    endtask

    initial begin
        bus.pll_locked  = 1'b1;
        bus.sysresetreq = 1'b0;
        bus.wdt_rst_req = 1'b0;
        bus.cause_clr   = 1'b0;

        // Power-on reset and first boot
        repeat (3) tick();
        chk("reset_outs", 32'(outs()), 32'h0);
        chk("reset_cause", 32'(bus.rst_cause), 32'h0);
        rst = 1'b0;
        boot("boot");
        chk("boot_cause", 32'(bus.rst_cause), 32'h0);

        // Core soft reset request
        bus.sysresetreq = 1'b1;
        tick();
        bus.sysresetreq = 1'b0;
        chk("sreq_outs_e", 32'(outs()), 32'h0);
        chk("sreq_cause", 32'(bus.rst_cause), 32'h2);
        for (int k = 1; k <= 14; k++) begin
            tick();
            chk("sreq_seq", 32'(outs()), 32'(seq_exp(k, 6)));
        end

        // Clear in the same cycle a watchdog request is accepted
        bus.wdt_rst_req = 1'b1;
        bus.cause_clr   = 1'b1;
        tick();
        bus.wdt_rst_req = 1'b0;
        bus.cause_clr   = 1'b0;
        chk("clr_wdt_cause", 32'(bus.rst_cause), 32'h4);
        chk("clr_wdt_outs", 32'(outs()), 32'h0);
        repeat (14) tick();
        chk("wdt_run", 32'(outs()), 32'hf);

        bus.cause_clr = 1'b1;
        tick();
        bus.cause_clr = 1'b0;
        chk("clr_only", 32'(bus.rst_cause), 32'h0);
        chk("clr_only_outs", 32'(outs()), 32'hf);

        // Lock loss and watchdog effective on the same edge
        bus.pll_locked = 1'b0;
        repeat (2) tick();
        chk("loss_pre", 32'(outs()), 32'hf);
        bus.wdt_rst_req = 1'b1;
        tick();
        bus.wdt_rst_req = 1'b0;
        chk("loss_outs", 32'(outs()), 32'h0);
        chk("loss_cause", 32'(bus.rst_cause), 32'h1);

        // Re-lock, then drop lock for 3 cycles at STABLE count 5
        bus.pll_locked = 1'b1;
        bus.cause_clr  = 1'b1;
        for (int r = 1; r <= 31; r++) begin
            tick();
            bus.cause_clr = 1'b0;
            if (r == 8)  bus.pll_locked = 1'b0;
            if (r == 11) bus.pll_locked = 1'b1;
            chk("relock", 32'(outs()), 32'(seq_exp(r, 22)));
        end
        chk("relock_cause", 32'(bus.rst_cause), 32'h0);

        // Power-on reset while in REL1
        bus.sysresetreq = 1'b1;
        tick();
        bus.sysresetreq = 1'b0;
        repeat (11) tick();
        chk("rel1_outs", 32'(outs()), 32'h3);
        chk("rel1_cause", 32'(bus.rst_cause), 32'h2);
        rst = 1'b1;
        tick();
        chk("por_outs", 32'(outs()), 32'h0);
        chk("por_cause", 32'(bus.rst_cause), 32'h0);
        tick();
        rst = 1'b0;
        boot("reboot");
        chk("reboot_cause", 32'(bus.rst_cause), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end
endmodule
